// File: rtl/vc_rsc_pkg.sv
// Shared definitions for the random stream checker:
// LFSR taps, FSM state encoding and the LFSR step function.
package vc_rsc_pkg;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/vc_random_stream_checker_if.sv
// Valid/ready message stream carrying a p_nbits payload.
// The producer drives val/msg, the consumer drives rdy.
interface vc_random_stream_checker_if #(
    parameter int p_nbits = 4
) ();

    logic               val;
    logic               rdy;
    logic [p_nbits-1:0] msg;

    modport master (output val, output msg, input  rdy);
    modport slave  (input  val, input  msg, output rdy);

endinterface

// File: rtl/vc_lfsr32.sv
// 32-bit right-shift Galois LFSR, reseeded by synchronous active-low reset,
// advancing one step on each cycle with en high.
module vc_lfsr32
    import vc_rsc_pkg::*;
#(
    parameter logic [31:0] p_seed = 32'hdeadbeef
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] state
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= p_seed;
        end else if (en) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/vc_random_stream_checker.sv
// Stream sink checking messages against a locally regenerated LFSR sequence.
// Optional random back-pressure: VC_RANDOM_STREAM_CHECKER_RAND_STALL_EN.
module vc_random_stream_checker
    import vc_rsc_pkg::*;
#(
    parameter int          p_nbits     = 4,
    parameter logic [31:0] p_seed      = 32'hdeadbeef,
    parameter int          p_cnt_nbits = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [p_cnt_nbits-1:0] num_msgs,
    vc_random_stream_checker_if.slave stream,
    output logic                   done,
    output logic                   pass,
    output logic [p_cnt_nbits-1:0] err_count,
    output logic [p_cnt_nbits-1:0] err_idx,
    output logic [p_nbits-1:0]     err_got,
    output logic [p_nbits-1:0]     err_exp
);

    localparam logic [p_cnt_nbits-1:0] CNT_ONE  = {{(p_cnt_nbits-1){1'b0}}, 1'b1};
    localparam logic [p_cnt_nbits-1:0] CNT_ZERO = '0;

    state_e state_q;
    state_e state_d;

    logic [p_cnt_nbits-1:0] remaining;
    logic [p_cnt_nbits-1:0] msg_idx;
    logic [31:0]            exp_lfsr;
    logic [p_nbits-1:0]     exp_msg;
    logic                   accept;
    logic                   load;
    logic                   mismatch;
    logic                   unused_exp_hi;

    assign accept   = stream.val && stream.rdy;
    assign load     = start && (state_q != RUN);
    assign exp_msg  = exp_lfsr[p_nbits-1:0];
    assign mismatch = stream.msg != exp_msg;

    // Only the low p_nbits of the LFSR form the expected payload.
    assign unused_exp_hi = ^exp_lfsr;

    vc_lfsr32 #(
        .p_seed (p_seed)
    ) u_exp_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .state (exp_lfsr)
    );

`ifdef VC_RANDOM_STREAM_CHECKER_RAND_STALL_EN
    logic [31:0] stall_lfsr;
    logic        unused_stall_hi;

    vc_lfsr32 #(
        .p_seed (~p_seed)
    ) u_stall_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == RUN),
        .state (stall_lfsr)
    );

    assign unused_stall_hi = ^stall_lfsr;
    assign stream.rdy = (state_q == RUN) && (stall_lfsr[1:0] != 2'b00);
`else
    assign stream.rdy = (state_q == RUN);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (num_msgs == CNT_ZERO) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && remaining == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // First mismatch of a run is detected while err_count is still zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            remaining <= '0;
            msg_idx   <= '0;
            err_count <= '0;
            err_idx   <= '0;
            err_got   <= '0;
            err_exp   <= '0;
        end else if (load) begin
            remaining <= num_msgs;
            msg_idx   <= '0;
            err_count <= '0;
            err_idx   <= '0;
            err_got   <= '0;
            err_exp   <= '0;
        end else if (accept) begin
            remaining <= remaining - CNT_ONE;
            msg_idx   <= msg_idx + CNT_ONE;
            if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + CNT_ONE;
                end
                if (err_count == CNT_ZERO) begin
                    err_idx <= msg_idx;
                    err_got <= stream.msg;
                    err_exp <= exp_msg;
                end
            end
        end
    end

    assign done = (state_q == DONE);
    assign pass = done && (err_count == CNT_ZERO);

endmodule

// File: tb/tb_vc_random_stream_checker.sv
// Directed vector table plus multi-cycle sequences for the stream checker
// (default build: p_nbits=4, seed 32'hdeadbeef, 16-bit counters).
module tb_vc_random_stream_checker;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] num_msgs;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] err_idx;
    logic [3:0]  err_got;
    logic [3:0]  err_exp;

    int checks;
    int errors;
    int stalls;

    logic [31:0] m;

    vc_random_stream_checker_if #(.p_nbits(4)) sif ();

    vc_random_stream_checker #(
        .p_nbits     (4),
        .p_seed      (32'hdeadbeef),
        .p_cnt_nbits (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_msgs  (num_msgs),
        .stream    (sif),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .err_idx   (err_idx),
        .err_got   (err_got),
        .err_exp   (err_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic [15:0] num;
        logic        val;
        logic [3:0]  msg;
        logic        rdy;
        logic        done;
        logic        pass;
        logic [15:0] ec;
        logic [15:0] eidx;
        logic [3:0]  egot;
        logic [3:0]  eexp;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t v(
        input int rst, input int st, input int num,
        input int val, input int msg, input int rdy,
        input int dn, input int ps, input int ec,
        input int eidx, input int egot, input int eexp
    );
        vec_t r;
        r.rst   = rst[0];
        r.start = st[0];
        r.num   = num[15:0];
        r.val   = val[0];
        r.msg   = msg[3:0];
        r.rdy   = rdy[0];
        r.done  = dn[0];
        r.pass  = ps[0];
        r.ec    = ec[15:0];
        r.eidx  = eidx[15:0];
        r.egot  = egot[3:0];
        r.eexp  = eexp[3:0];
        return r;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        start    = 1'b0;
        sif.val  = 1'b0;
        step();
        reset    = 1'b1;
        m        = 32'hdeadbeef;
    endtask

    task automatic send(input logic [3:0] flip);
        int n;
        n       = 0;
        sif.val = 1'b1;
        sif.msg = m[3:0] ^ flip;
        while (!sif.rdy && n < 50) begin
            stalls++;
            step();
            n++;
        end
        chk("rdy_wait", 32'(n < 50), 32'd1);
        step();
        sif.val = 1'b0;
        m = lfsr_next(m);
    endtask

    initial begin
        logic [3:0] got137;
        logic [3:0] exp137;
        int         k;
        checks   = 0;
        errors   = 0;
        stalls   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        num_msgs = '0;
        sif.val  = 1'b0;
        sif.msg  = '0;
        got137   = '0;
        exp137   = '0;

        tbl[0]  = v(0,1,3,0,'h0, 0,0,0,0,0,'h0,'h0);
        tbl[1]  = v(0,0,0,1,'hf, 1,0,0,0,0,'h0,'h0);
        tbl[2]  = v(0,0,0,1,'h4, 1,0,0,0,0,'h0,'h0);
        tbl[3]  = v(0,0,0,1,'ha, 1,1,1,0,0,'h0,'h0);
        tbl[4]  = v(0,0,0,0,'h0, 0,1,1,0,0,'h0,'h0);
        tbl[5]  = v(1,0,0,0,'h0, 0,0,0,0,0,'h0,'h0);
        tbl[6]  = v(0,1,3,0,'h0, 0,0,0,0,0,'h0,'h0);
        tbl[7]  = v(0,0,0,1,'hf, 1,0,0,0,0,'h0,'h0);
        tbl[8]  = v(0,0,0,1,'h5, 1,0,0,1,1,'h5,'h4);
        tbl[9]  = v(0,0,0,1,'ha, 1,1,0,1,1,'h5,'h4);
        tbl[10] = v(0,1,0,0,'h0, 0,1,1,0,0,'h0,'h0);
        tbl[11] = v(0,0,0,1,'h7, 0,1,1,0,0,'h0,'h0);
        tbl[12] = v(0,1,2,1,'h0, 0,0,0,0,0,'h0,'h0);
        tbl[13] = v(0,0,0,1,'hd, 1,0,0,0,0,'h0,'h0);
        tbl[14] = v(0,0,0,0,'h0, 1,0,0,0,0,'h0,'h0);
        tbl[15] = v(0,0,0,1,'h3, 1,1,0,1,1,'h3,'hd);
        tbl[16] = v(0,1,1,0,'h0, 0,0,0,0,0,'h0,'h0);
        tbl[17] = v(0,0,0,1,'h5, 1,1,1,0,0,'h0,'h0);

        step();
        step();
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_pass", 32'(pass), 32'd0);
        chk("reset_rdy", 32'(sif.rdy), 32'd0);
        chk("reset_ec", 32'(err_count), 32'd0);
        chk("reset_egot", 32'(err_got), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            reset    = ~tbl[i].rst;
            start    = tbl[i].start;
            num_msgs = tbl[i].num;
            sif.val  = tbl[i].val;
            sif.msg  = tbl[i].msg;
            chk($sformatf("row%0d_rdy", i), 32'(sif.rdy), 32'(tbl[i].rdy));
            step();
            chk($sformatf("row%0d_done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("row%0d_pass", i), 32'(pass), 32'(tbl[i].pass));
            chk($sformatf("row%0d_ec", i), 32'(err_count), 32'(tbl[i].ec));
            chk($sformatf("row%0d_eidx", i), 32'(err_idx), 32'(tbl[i].eidx));
            chk($sformatf("row%0d_egot", i), 32'(err_got), 32'(tbl[i].egot));
            chk($sformatf("row%0d_eexp", i), 32'(err_exp), 32'(tbl[i].eexp));
        end
        reset   = 1'b1;
        start   = 1'b0;
        sif.val = 1'b0;

        // Idle gap mid-run: wrong payloads with val low must be ignored.
        do_reset();
        start = 1'b1; num_msgs = 16'd4;
        step();
        start = 1'b0;
        send(4'h0);
        send(4'h0);
        for (int i = 0; i < 5; i++) begin
            sif.val = 1'b0;
            sif.msg = ~m[3:0];
            step();
            chk("hold_ec", 32'(err_count), 32'd0);
            chk("hold_done", 32'(done), 32'd0);
        end
        chk("hold_resume_exp", 32'(m[3:0]), 32'hA);
        send(4'h0);
        send(4'h0);
        chk("hold_done_end", 32'(done), 32'd1);
        chk("hold_pass_end", 32'(pass), 32'd1);
        chk("hold_ec_end", 32'(err_count), 32'd0);

        // Empty run from IDLE.
        do_reset();
        start = 1'b1; num_msgs = 16'd0;
        sif.val = 1'b1; sif.msg = 4'h3;
        chk("zero_rdy0", 32'(sif.rdy), 32'd0);
        step();
        start = 1'b0;
        chk("zero_rdy1", 32'(sif.rdy), 32'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_pass", 32'(pass), 32'd1);
        step();
        chk("zero_rdy2", 32'(sif.rdy), 32'd0);
        sif.val = 1'b0;

        // Reset after two of five accepts reseeds the expected sequence.
        do_reset();
        start = 1'b1; num_msgs = 16'd5;
        step();
        start = 1'b0;
        send(4'h0);
        send(4'h0);
        do_reset();
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rdy", 32'(sif.rdy), 32'd0);
        start = 1'b1; num_msgs = 16'd1;
        step();
        start = 1'b0;
        chk("abort_first_exp", 32'(m[3:0]), 32'hF);
        send(4'h0);
        chk("abort_done_end", 32'(done), 32'd1);
        chk("abort_pass_end", 32'(pass), 32'd1);

        // Long run with gaps and one corrupted message at index 137.
        do_reset();
        start = 1'b1; num_msgs = 16'd200;
        step();
        start = 1'b0;
        for (k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 2)) begin
                sif.val = 1'b0;
                sif.msg = 4'($urandom);
                step();
            end
            if (k == 137) begin
                got137 = m[3:0] ^ 4'h6;
                exp137 = m[3:0];
            end
            send(k == 137 ? 4'h6 : 4'h0);
        end
        chk("long_done", 32'(done), 32'd1);
        chk("long_pass", 32'(pass), 32'd0);
        chk("long_ec", 32'(err_count), 32'd1);
        chk("long_eidx", 32'(err_idx), 32'd137);
        chk("long_egot", 32'(err_got), 32'(got137));
        chk("long_eexp", 32'(err_exp), 32'(exp137));

        // Second run continues the sequence without reseeding.
        start = 1'b1; num_msgs = 16'd200;
        step();
        start = 1'b0;
        chk("cont_done_clr", 32'(done), 32'd0);
        for (k = 0; k < 200; k++) begin
            send(4'h0);
        end
        chk("cont_done", 32'(done), 32'd1);
        chk("cont_pass", 32'(pass), 32'd1);
        chk("cont_ec", 32'(err_count), 32'd0);

`ifdef VC_RANDOM_STREAM_CHECKER_RAND_STALL_EN
        chk("stall_seen", 32'(stalls > 0), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
